// File: rtl/bomb_fuse_pkg.sv
// bomb_pkg: shared states, screen/bomb geometry constants and the flame record used by bomb_fuse.
package bomb_pkg;

   typedef enum logic [1:0] {IDLE, FUSE, BLAST} fuse_state_t;

   localparam int SCREEN_X_MAX = 639;
   localparam int SCREEN_Y_MAX = 479;
   localparam int BOMB_W       = 20;
   localparam int BOMB_H       = 25;

   typedef struct packed {
      logic [9:0] hx;
      logic [9:0] hxs;
      logic [9:0] hy;
      logic [9:0] hys;
      logic [9:0] vx;
      logic [9:0] vxs;
      logic [9:0] vy;
      logic [9:0] vys;
   } flame_t;

   function automatic logic [9:0] sat(input logic signed [11:0] v, input logic signed [11:0] lim);
      return v[11] ? 10'd0 : (v > lim) ? lim[9:0] : v[9:0];
   endfunction

endpackage

// File: rtl/bomb_fuse_flame_clamp.sv
// flame_clamp: one axis of the flame cross; centre +/- reach saturated to [0, LIMIT],
// plus the thin-arm origin (centre - THICK/2, floored at 0).
module flame_clamp
   import bomb_pkg::*;
#(
   parameter int REACH = 64,
   parameter int THICK = 16,
   parameter int LIMIT = 639
) (
   input  logic [9:0] pos,
   input  logic [9:0] half,
   output logic [9:0] org,
   output logic [9:0] ext,
   output logic [9:0] thin
);

   localparam logic signed [11:0] R   = 12'(REACH);
   localparam logic signed [11:0] T   = 12'(THICK / 2);
   localparam logic signed [11:0] LIM = 12'(LIMIT);

   logic signed [11:0] c;

   always_comb begin
      c    = $signed({2'b00, pos}) + $signed({2'b00, half});
      org  = sat(c - R, LIM);
      ext  = sat(c + R, LIM) - org;
      thin = sat(c - T, LIM);
   end

endmodule

// File: rtl/bomb_fuse.sv
// bomb_fuse: fuse timer and cross-shaped blast generator, one tick per video frame.
// Optional sprite blink in the last quarter of the fuse when BOMB_FUSE_BLINK_EN is defined.
module bomb_fuse
   import bomb_pkg::*;
#(
   parameter int FUSE_FRAMES  = 180,
   parameter int BLAST_FRAMES = 30,
   parameter int REACH_PX     = 64,
   parameter int THICK_PX     = 16
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       bomb_check,
   input  logic [9:0] bombX,
   input  logic [9:0] bombY,
   output logic       explode,
   output logic       flame_active,
   output logic [9:0] flameHX,
   output logic [9:0] flameHY,
   output logic [9:0] flameHXS,
   output logic [9:0] flameHYS,
   output logic [9:0] flameVX,
   output logic [9:0] flameVY,
   output logic [9:0] flameVXS,
   output logic [9:0] flameVYS,
   output logic       bomb_blink
);

   fuse_state_t state_q, state_d;
   logic [9:0]  count_q, count_d;
   logic [9:0]  xl_q, xl_d, yl_q, yl_d;
   logic        explode_q, explode_d;
   logic        active_q, active_d;
   flame_t      flame_q, flame_d, flame_n;
   logic [9:0]  x_org, x_ext, x_thin, y_org, y_ext, y_thin;

   flame_clamp #(.REACH(REACH_PX), .THICK(THICK_PX), .LIMIT(SCREEN_X_MAX)) u_x (
      .pos(xl_q), .half(10'(BOMB_W / 2)), .org(x_org), .ext(x_ext), .thin(x_thin)
   );

   flame_clamp #(.REACH(REACH_PX), .THICK(THICK_PX), .LIMIT(SCREEN_Y_MAX)) u_y (
      .pos(yl_q), .half(10'(BOMB_H / 2)), .org(y_org), .ext(y_ext), .thin(y_thin)
   );

   assign flame_n = '{hx: x_org, hxs: x_ext, hy: y_thin, hys: 10'(THICK_PX),
                      vx: x_thin, vxs: 10'(THICK_PX), vy: y_org, vys: y_ext};

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      xl_d      = xl_q;
      yl_d      = yl_q;
      explode_d = 1'b0;
      active_d  = active_q;
      flame_d   = flame_q;
      unique case (state_q)
         IDLE: if (bomb_check) begin
            state_d = FUSE;
            xl_d    = bombX;
            yl_d    = bombY;
            count_d = 10'(FUSE_FRAMES - 1);
         end
         FUSE: if (!bomb_check) begin
            state_d = IDLE;
            count_d = '0;
         end else if (count_q == '0) begin
            state_d   = BLAST;
            explode_d = 1'b1;
            active_d  = 1'b1;
            flame_d   = flame_n;
            count_d   = 10'(BLAST_FRAMES - 1);
         end else begin
            count_d = count_q - 10'd1;
         end
         BLAST: if (count_q == '0) begin
            state_d  = IDLE;
            active_d = 1'b0;
            flame_d  = '0;
         end else begin
            count_d = count_q - 10'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         xl_q      <= '0;
         yl_q      <= '0;
         explode_q <= 1'b0;
         active_q  <= 1'b0;
         flame_q   <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         xl_q      <= xl_d;
         yl_q      <= yl_d;
         explode_q <= explode_d;
         active_q  <= active_d;
         flame_q   <= flame_d;
      end
   end

`ifdef BOMB_FUSE_BLINK_EN
   logic blink_q, blink_d;

   // Blink follows the count that will be held after this edge, so it lines up with state.
   assign blink_d = (state_d == FUSE && count_d < 10'(FUSE_FRAMES / 4)) ? count_d[3] : 1'b0;

   always_ff @(posedge frame_clk) begin
      if (Reset) blink_q <= 1'b0;
      else       blink_q <= blink_d;
   end

   assign bomb_blink = blink_q;
`else
   assign bomb_blink = 1'b0;
`endif

   assign explode      = explode_q;
   assign flame_active = active_q;
   assign flameHX      = flame_q.hx;
   assign flameHXS     = flame_q.hxs;
   assign flameHY      = flame_q.hy;
   assign flameHYS     = flame_q.hys;
   assign flameVX      = flame_q.vx;
   assign flameVXS     = flame_q.vxs;
   assign flameVY      = flame_q.vy;
   assign flameVYS     = flame_q.vys;

endmodule
